// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) game core.
// Optional feature macro used by genius_core: GENIUS_RETRY_EN.
package genius_pkg;

  // One colour of the four-colour game.
  typedef logic [1:0] color_t;

  // Game phase.
  typedef enum logic [1:0] {
    GEN   = 2'd0,
    PLAY  = 2'd1,
    WIN   = 2'd2,
    ERROR = 2'd3
  } state_t;

  // Default sequence length.
  localparam int GENIUS_DEPTH = 4;

  // Index width for a sequence of the given depth (never below one bit).
  function automatic int genius_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/genius_seq_mem.sv
// Sequence store: DEPTH colours, cleared by the async reset,
// written synchronously and read combinationally.
module genius_seq_mem
  import genius_pkg::*;
#(
  parameter  int DEPTH = GENIUS_DEPTH,
  localparam int AW    = genius_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  color_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output color_t        rdata_o
);

  color_t mem_q [DEPTH];

  // Storage array: whole array cleared on reset, one entry written per strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 2'b00;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end else begin
      mem_q <= mem_q;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/genius_core.sv
// Genius game control core: records a colour sequence from the PRNG,
// then checks player entries against it in order.
// Build option GENIUS_RETRY_EN: WIN restarts a new game, ERROR replays
// the stored sequence; without it both end states hold until reset.
module genius_core
  import genius_pkg::*;
#(
  parameter  int DEPTH = GENIUS_DEPTH,
  localparam int AW    = genius_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  color_t        value_in,
  input  color_t        player_input,
  input  logic          input_ready,
  output logic          gen_enable,
  output logic          mem_write,
  output logic          score_inc,
  output logic          error_led,
  output logic          win,
  output logic          correct,
  output color_t        mem_out,
  output logic [AW-1:0] idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          we_s;
  logic          score_s;
  color_t        rd_s;

  genius_seq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_s),
    .waddr_i (idx_q),
    .wdata_i (value_in),
    .raddr_i (idx_q),
    .rdata_o (rd_s)
  );

  // State and index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= GEN;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; the write and score strobes share the event's edge.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_s    = 1'b0;
    score_s = 1'b0;
    case (state_q)
      GEN: begin
        if (input_ready) begin
          we_s = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = PLAY;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      PLAY: begin
        if (input_ready) begin
          if (player_input == rd_s) begin
            score_s = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = WIN;
            end else begin
              idx_d = idx_q + AW'(1);
            end
          end else begin
            state_d = ERROR;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      WIN: begin
`ifdef GENIUS_RETRY_EN
        if (input_ready) begin
          idx_d   = '0;
          state_d = GEN;
        end else begin
          state_d = WIN;
        end
`else
        state_d = WIN;
`endif
      end
      ERROR: begin
`ifdef GENIUS_RETRY_EN
        if (input_ready) begin
          idx_d   = '0;
          state_d = PLAY;
        end else begin
          state_d = ERROR;
        end
`else
        state_d = ERROR;
`endif
      end
      default: begin
        idx_d   = '0;
        state_d = GEN;
      end
    endcase
  end

  assign gen_enable = (state_q == GEN);
  assign error_led  = (state_q == ERROR);
  assign win        = (state_q == WIN);
  assign mem_write  = we_s;
  assign score_inc  = score_s;
  assign correct    = (player_input == rd_s);
  assign mem_out    = rd_s;
  assign idx        = idx_q;

endmodule

// File: tb/tb_genius_core.sv
// Self-checking bench for genius_core: directed game scenarios followed by
// randomized games, all checked against a sequence/position game model.
module tb_genius_core;

  localparam int DEPTH = 4;
  localparam int P_GEN  = 0;
  localparam int P_PLAY = 1;
  localparam int P_WIN  = 2;
  localparam int P_ERR  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] value_in;
  logic [1:0] player_input;
  logic       input_ready;
  logic       gen_enable, mem_write, score_inc, error_led, win, correct;
  logic [1:0] mem_out;
  logic [1:0] idx;

  int checks = 0;
  int errors = 0;

  // Game model: recorded colours, current position, phase, hit count.
  logic [1:0] m_seq [DEPTH];
  int         m_pos;
  int         m_phase;
  int         scores;

  genius_core #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .value_in     (value_in),
    .player_input (player_input),
    .input_ready  (input_ready),
    .gen_enable   (gen_enable),
    .mem_write    (mem_write),
    .score_inc    (score_inc),
    .error_led    (error_led),
    .win          (win),
    .correct      (correct),
    .mem_out      (mem_out),
    .idx          (idx)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_seq[i] = 2'b00;
    m_pos   = 0;
    m_phase = P_GEN;
  endtask

  // Called shortly after a rising edge: asserts reset asynchronously,
  // checks the outputs before any clock edge, then releases it.
  task automatic do_reset();
    input_ready = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_gen_enable", 32'(gen_enable), 32'd1);
    chk("rst_idx",        32'(idx),        32'd0);
    chk("rst_error_led",  32'(error_led),  32'd0);
    chk("rst_win",        32'(win),        32'd0);
    chk("rst_mem_out",    32'(mem_out),    32'd0);
    chk("rst_mem_write",  32'(mem_write),  32'd0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock cycle with the given inputs: check every output against the
  // model, take the edge, then advance the model.
  task automatic step(input logic rdy, input logic [1:0] val, input logic [1:0] ply);
    logic [1:0] cur;
    logic       hit;
    input_ready  = rdy;
    value_in     = val;
    player_input = ply;
    #1;
    cur = m_seq[m_pos];
    hit = (ply == cur);
    chk("gen_enable", 32'(gen_enable), 32'(m_phase == P_GEN));
    chk("error_led",  32'(error_led),  32'(m_phase == P_ERR));
    chk("win",        32'(win),        32'(m_phase == P_WIN));
    chk("idx",        32'(idx),        32'(m_pos));
    chk("mem_out",    32'(mem_out),    32'(cur));
    chk("correct",    32'(correct),    32'(hit));
    chk("mem_write",  32'(mem_write),  32'(m_phase == P_GEN && rdy));
    chk("score_inc",  32'(score_inc),  32'(m_phase == P_PLAY && rdy && hit));
    if (score_inc === 1'b1) scores++;
    @(posedge clk);
    if (rdy) begin
      case (m_phase)
        P_GEN: begin
          m_seq[m_pos] = val;
          m_pos++;
          if (m_pos == DEPTH) begin
            m_pos   = 0;
            m_phase = P_PLAY;
          end
        end
        P_PLAY: begin
          if (hit) begin
            m_pos++;
            if (m_pos == DEPTH) begin
              m_pos   = 0;
              m_phase = P_WIN;
            end
          end else begin
            m_phase = P_ERR;
          end
        end
`ifdef GENIUS_RETRY_EN
        P_WIN: begin
          m_pos   = 0;
          m_phase = P_GEN;
        end
        P_ERR: begin
          m_pos   = 0;
          m_phase = P_PLAY;
        end
`endif
        default: ;
      endcase
    end
    #1;
  endtask

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] rec [4];
    rec[0] = 2'd1; rec[1] = 2'd3; rec[2] = 2'd0; rec[3] = 2'd2;
    rst = 1'b1;
    input_ready = 1'b0;
    value_in = 2'd0;
    player_input = 2'd0;
    model_reset();
    scores = 0;
    #1;

    // Reset, record 1,3,0,2, then a perfect game.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, rec[i], 2'd0);
    chk("rec_in_play", 32'(gen_enable), 32'd0);
    chk("rec_idx0",    32'(idx),        32'd0);
    scores = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, rec[i]);
    chk("perfect_hits", 32'(scores), 32'd4);
    chk("perfect_win",  32'(win),    32'd1);
    chk("perfect_err",  32'(error_led), 32'd0);
    step(1'b1, 2'd0, 2'd1);
    step(1'b0, 2'd0, 2'd1);

    // Miss on the second entry.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, rec[i], 2'd0);
    scores = 0;
    step(1'b1, 2'd0, 2'd1);
    step(1'b1, 2'd0, 2'd2);
    chk("miss_hits", 32'(scores),    32'd1);
    chk("miss_err",  32'(error_led), 32'd1);
    chk("miss_idx",  32'(idx),       32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 2'(i));

    // Held strobe in GEN, then reset mid-PLAY at idx 2.
    do_reset();
    step(1'b1, 2'd2, 2'd0);
    step(1'b1, 2'd1, 2'd0);
    chk("held_idx", 32'(idx), 32'd2);
    step(1'b1, 2'd3, 2'd0);
    step(1'b1, 2'd1, 2'd0);
    step(1'b1, 2'd0, 2'd2);
    step(1'b1, 2'd0, 2'd1);
    chk("midplay_idx", 32'(idx), 32'd2);
    do_reset();
    // Walk the cleared store: the model expects 0 at every index.
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 2'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 2'd0);

    // Randomized games.
    for (int g = 0; g < 30; g++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        logic       rdy;
        logic [1:0] val, ply;
        rdy = ($urandom_range(0, 3) != 0);
        val = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) ply = 2'($urandom_range(0, 3));
        else ply = m_seq[m_pos];
        step(rdy, val, ply);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
